aer_in_arbiter: RTL and testbench

Shares ODIN's single AER input link (4-phase REQ/ACK with 17-bit address) among N_SRC on-chip event sources.
- Each source offers one address through a valid/ready handshake.
- The block picks a winner round-robin and latches its address.
- It then drives one full 4-phase transaction on AERIN_* before granting again.
- It sits between the stimulus generators / spike routers and the ODIN AERIN port.

---
 rtl/aer_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/aer_in_arbiter.sv | 135 +++++++++++++
 tb/tb_aer_in_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared definitions for the AER input arbiter: FSM state encoding and the
// default AER address width of the ODIN AERIN port.
package aer_pkg;

    localparam int DEF_ADDR_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_WAIT_ACK_HIGH = 2'd3,
        ST_WAIT_ACK_LOW  = 2'd1
    } aer_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping modulo N. Returns one-hot grant, its index and any_req.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    logic found;

    // Two passes: indices above the pointer first, then the wrapped range.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = |req;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/aer_in_arbiter.sv
// Shares one 4-phase AER input link among N_SRC valid/ready sources.
// Optional macro AER_ACK_SYNC_EN adds a 2-flop synchronizer on AERIN_ACK.
//   state            | meaning
//   ST_IDLE          | no transaction; grant the round-robin winner
//   ST_WAIT_ACK_HIGH | REQ high, waiting for ACK to rise
//   ST_WAIT_ACK_LOW  | REQ low, waiting for ACK to fall, then count
module aer_in_arbiter #(
    parameter  int N_SRC  = 4,
    parameter  int ADDR_W = aer_pkg::DEF_ADDR_W,
    parameter  int CNT_W  = 16,
    localparam int ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_SRC-1:0]        SRC_VALID,
    input  logic [N_SRC*ADDR_W-1:0] SRC_ADDR,
    output logic [N_SRC-1:0]        SRC_READY,
    output logic                    AERIN_REQ,
    output logic [ADDR_W-1:0]       AERIN_ADDR,
    input  logic                    AERIN_ACK,
    output logic [ID_W-1:0]         GRANT_ID,
    output logic                    BUSY,
    output logic [CNT_W-1:0]        EVT_CNT
);

    import aer_pkg::*;

    aer_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   gid_q;
    logic [ID_W-1:0]   rr_idx;
    logic [N_SRC-1:0]  rr_gnt;
    logic              rr_any;
    logic              ack_s;
    logic              accept;
    logic              done;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [CNT_W-1:0]  cnt_q;

`ifdef AER_ACK_SYNC_EN
    logic ack_meta, ack_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= AERIN_ACK;
            ack_sync <= ack_meta;
        end
    end

    assign ack_s = ack_sync;
`else
    assign ack_s = AERIN_ACK;
`endif

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (ID_W)
    ) u_rr (
        .req     (SRC_VALID),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .idx     (rr_idx),
        .any_req (rr_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (rr_gnt[i]) sel_addr = SRC_ADDR[i*ADDR_W +: ADDR_W];
        end
    end

    // READY is masked during reset so no transfer is offered while RST is high.
    always_comb begin
        state_d   = state_q;
        SRC_READY = '0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_any && !RST) begin
                    SRC_READY = rr_gnt;
                    accept    = 1'b1;
                    state_d   = ST_WAIT_ACK_HIGH;
                end
            end
            ST_WAIT_ACK_HIGH: begin
                if (ack_s) state_d = ST_WAIT_ACK_LOW;
            end
            ST_WAIT_ACK_LOW: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            gid_q  <= '0;
            ptr_q  <= ID_W'(N_SRC - 1);
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                addr_q <= sel_addr;
                gid_q  <= rr_idx;
                ptr_q  <= rr_idx;
                req_q  <= 1'b1;
            end
            if ((state_q == ST_WAIT_ACK_HIGH) && ack_s) req_q <= 1'b0;
            if (done) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign AERIN_REQ  = req_q;
    assign AERIN_ADDR = addr_q;
    assign GRANT_ID   = gid_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign EVT_CNT    = cnt_q;

endmodule

// File: tb/tb_aer_in_arbiter.sv
// Directed bench for aer_in_arbiter with a simple ODIN ACK model.
module tb_aer_in_arbiter;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int CW = 4;
`ifdef AER_ACK_SYNC_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 1;
`endif

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    SRC_VALID = '0;
    logic [N*AW-1:0] SRC_ADDR;
    logic [N-1:0]    SRC_READY;
    logic            AERIN_REQ;
    logic [AW-1:0]   AERIN_ADDR;
    logic            AERIN_ACK = 1'b0;
    logic [1:0]      GRANT_ID;
    logic            BUSY;
    logic [CW-1:0]   EVT_CNT;

    aer_in_arbiter #(.N_SRC(N), .ADDR_W(AW), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SRC_VALID  (SRC_VALID),
        .SRC_ADDR   (SRC_ADDR),
        .SRC_READY  (SRC_READY),
        .AERIN_REQ  (AERIN_REQ),
        .AERIN_ADDR (AERIN_ADDR),
        .AERIN_ACK  (AERIN_ACK),
        .GRANT_ID   (GRANT_ID),
        .BUSY       (BUSY),
        .EVT_CNT    (EVT_CNT)
    );

    always #5 CLK = ~CLK;

    logic [AW-1:0] src_a [N];
    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ODIN model: ACK rises 2 cycles after REQ, falls 2 cycles after REQ drops.
    logic odin_hold = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            AERIN_ACK = 1'b0;
            hi_cnt    = 0;
            lo_cnt    = 0;
        end else if (AERIN_REQ && !AERIN_ACK) begin
            lo_cnt = 0;
            if (!odin_hold) begin
                hi_cnt++;
                if (hi_cnt >= 2) begin
                    AERIN_ACK = 1'b1;
                    hi_cnt    = 0;
                end
            end
        end else if (!AERIN_REQ && AERIN_ACK) begin
            lo_cnt++;
            if (lo_cnt >= 2) begin
                AERIN_ACK = 1'b0;
                lo_cnt    = 0;
            end
        end
    end

    int   multi_ready = 0;
    int   ready_with_req = 0;
    int   req_rises = 0;
    logic req_prev = 1'b0;
    always @(negedge CLK) begin
        if ($countones(SRC_READY) > 1) multi_ready++;
        if ((SRC_READY != '0) && AERIN_REQ) ready_with_req++;
        if (AERIN_REQ && !req_prev) req_rises++;
        req_prev = AERIN_REQ;
    end

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  ready;
        logic [1:0]    gid;
        logic [AW-1:0] addr;
    } vec_t;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (BUSY && n < 500);
        chk({tag, "_idle"}, BUSY, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        SRC_VALID = '0;
        repeat (3) @(posedge CLK);
        #3;
        RST = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge CLK); #1;
        SRC_VALID = v.valid;
        @(negedge CLK);
        chk({tag, "_ready"}, SRC_READY, v.ready);
        chk({tag, "_busy0"}, BUSY, 0);
        if (v.ready != '0) begin
            @(posedge CLK); #1;
            SRC_VALID = '0;
            chk({tag, "_req"}, AERIN_REQ, 1);
            chk({tag, "_addr"}, AERIN_ADDR, v.addr);
            chk({tag, "_gid"}, GRANT_ID, v.gid);
            chk({tag, "_busy1"}, BUSY, 1);
            chk({tag, "_ready_off"}, SRC_READY, 0);
            wait_idle(tag);
            exp_cnt++;
            chk({tag, "_cnt"}, EVT_CNT, exp_cnt % 16);
            chk({tag, "_addr_hold"}, AERIN_ADDR, v.addr);
        end else begin
            repeat (3) @(posedge CLK);
            #1;
            chk({tag, "_stay_idle"}, {AERIN_REQ, BUSY}, 2'b00);
            SRC_VALID = '0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   n, lat, bad, r0, k;
        logic [N-1:0] oh;

        src_a[0] = 17'h1FFFF;
        src_a[1] = 17'h00001;
        src_a[2] = 17'h00A07;
        src_a[3] = 17'h15555;
        SRC_ADDR = {src_a[3], src_a[2], src_a[1], src_a[0]};

        // Pointer starts at 3 after reset and follows each winner.
        vecs[0] = '{4'b0100, 4'b0100, 2'd2, src_a[2]};
        vecs[1] = '{4'b1111, 4'b1000, 2'd3, src_a[3]};
        vecs[2] = '{4'b1111, 4'b0001, 2'd0, src_a[0]};
        vecs[3] = '{4'b0001, 4'b0001, 2'd0, src_a[0]};
        vecs[4] = '{4'b1010, 4'b0010, 2'd1, src_a[1]};
        vecs[5] = '{4'b1010, 4'b1000, 2'd3, src_a[3]};
        vecs[6] = '{4'b0110, 4'b0010, 2'd1, src_a[1]};
        vecs[7] = '{4'b0011, 4'b0001, 2'd0, src_a[0]};
        vecs[8] = '{4'b0000, 4'b0000, 2'd0, src_a[0]};

        do_reset();
        @(negedge CLK);
        chk("rst_req", AERIN_REQ, 0);
        chk("rst_addr", AERIN_ADDR, 0);
        chk("rst_ready", SRC_READY, 0);
        chk("rst_gid", GRANT_ID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cnt", EVT_CNT, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ACK held low: REQ and address must stay put, other sources wait.
        odin_hold = 1'b1;
        @(posedge CLK); #1;
        SRC_VALID = 4'b0001;
        @(posedge CLK); #1;
        SRC_VALID = 4'b1110;
        chk("hold_gid", GRANT_ID, 0);
        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (!(AERIN_REQ && (AERIN_ADDR == src_a[0]) && BUSY && (SRC_READY == '0))) bad++;
        end
        chk("hold_stable", bad, 0);
        @(posedge CLK); #1;
        odin_hold = 1'b0;
        SRC_VALID = '0;
        wait_idle("hold");
        exp_cnt++;
        chk("hold_cnt", EVT_CNT, exp_cnt % 16);

        // Reset while in WAIT_ACK_LOW: event lost, counter cleared.
        @(posedge CLK); #1;
        SRC_VALID = 4'b0100;
        @(posedge CLK); #1;
        SRC_VALID = '0;
        chk("rlow_gid", GRANT_ID, 2);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(!AERIN_REQ && BUSY) && n < 100);
        chk("rlow_reach", {AERIN_REQ, BUSY}, 2'b01);
        RST = 1'b1;
        #1;
        chk("rlow_req", AERIN_REQ, 0);
        chk("rlow_cnt", EVT_CNT, 0);
        chk("rlow_busy", BUSY, 0);
        chk("rlow_addr", AERIN_ADDR, 0);
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        exp_cnt = 0;
        run_vec('{4'b1010, 4'b0010, 2'd1, src_a[1]}, "post_rst");

        // ACK-rise to REQ-fall latency.
        @(posedge CLK); #1;
        SRC_VALID = 4'b1000;
        @(posedge CLK); #1;
        SRC_VALID = '0;
        chk("lat_gid", GRANT_ID, 3);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!AERIN_ACK && n < 50);
        lat = 0;
        while (AERIN_REQ && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        chk("ack_to_req_fall", lat, EXP_LAT);
        wait_idle("lat");
        exp_cnt++;
        chk("lat_cnt", EVT_CNT, exp_cnt % 16);

        // All sources valid: strict rotation from source 0, counter wraps at 16.
        do_reset();
        r0 = req_rises;
        @(posedge CLK); #1;
        SRC_VALID = 4'b1111;
        for (int e = 0; e < 16; e++) begin
            k = 0;
            do begin
                @(negedge CLK);
                k++;
            end while ((SRC_READY & SRC_VALID) == '0 && k < 100);
            oh = SRC_READY;
            if (e == 8) chk("rr_cnt8", EVT_CNT, 8);
            chk($sformatf("rr_order%0d", e), oh_idx(oh), e % 4);
            @(posedge CLK);
            if (e == 15) begin
                #1;
                SRC_VALID = '0;
            end
        end
        wait_idle("rr");
        chk("rr_wrap_cnt", EVT_CNT, 0);
        chk("rr_req_rises", req_rises - r0, 16);
        chk("rr_last_gid", GRANT_ID, 3);
        chk("multi_ready", multi_ready, 0);
        chk("ready_with_req", ready_with_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
